// File: rtl/vscale_dmem_rr_scheduler.sv
// Round-robin core selector for the shared vscale data-memory arbiter.
// One transfer (address + data phase) at a time, with lock hold and starvation override.
module vscale_dmem_rr_scheduler #(
    parameter int NUM_CORES         = 4,
    parameter int CORE_IDX_WIDTH    = 2,
    parameter int HASTI_TRANS_WIDTH = 2,
    parameter int WAIT_CNT_WIDTH    = 8,
    parameter int MAX_WAIT          = 64
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_CORES*HASTI_TRANS_WIDTH-1:0] core_htrans,
    input  logic [NUM_CORES-1:0]                   core_hmastlock,
    input  logic                                   dmem_hready,
    output logic [CORE_IDX_WIDTH-1:0]              next_core,
    output logic [NUM_CORES-1:0]                   grant,
    output logic                                   busy,
    output logic [NUM_CORES-1:0]                   starve_flag
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    localparam logic [WAIT_CNT_WIDTH-1:0] MaxWaitC = WAIT_CNT_WIDTH'(MAX_WAIT);
    localparam logic [CORE_IDX_WIDTH-1:0] LastIdxC = CORE_IDX_WIDTH'(NUM_CORES - 1);

    state_t                      state_q, state_d;
    logic [CORE_IDX_WIDTH-1:0]   next_core_q, next_core_d;
    logic [CORE_IDX_WIDTH-1:0]   last_q, last_d;
    logic [NUM_CORES-1:0]        starve_q, starve_d;
    logic [WAIT_CNT_WIDTH-1:0]   cnt_q [NUM_CORES];
    logic [WAIT_CNT_WIDTH-1:0]   cnt_d [NUM_CORES];

    logic [NUM_CORES-1:0]        req;
    logic                        anyReq;
    logic                        arbitrate;
    logic [CORE_IDX_WIDTH-1:0]   winner;
    logic                        found;

    // NONSEQ and SEQ count as requests; IDLE and BUSY do not.
    always_comb begin
        req = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            req[i] = (core_htrans[i*HASTI_TRANS_WIDTH +: HASTI_TRANS_WIDTH] == HASTI_TRANS_WIDTH'(2))
                  || (core_htrans[i*HASTI_TRANS_WIDTH +: HASTI_TRANS_WIDTH] == HASTI_TRANS_WIDTH'(3));
        end
    end

    assign anyReq    = |req;
    assign arbitrate = anyReq && ((state_q == IDLE) || ((state_q == DATA) && dmem_hready));

    // Starved requester first, then a locked owner, then the RR scan from last+1.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (!found && starve_q[i] && req[i]) begin
                winner = CORE_IDX_WIDTH'(i);
                found  = 1'b1;
            end
        end
        if (!found && (state_q == DATA) && core_hmastlock[next_core_q] && req[next_core_q]) begin
            winner = next_core_q;
            found  = 1'b1;
        end
        for (int k = 1; k <= NUM_CORES; k++) begin
            if (!found && req[(int'(last_q) + k) % NUM_CORES]) begin
                winner = CORE_IDX_WIDTH'((int'(last_q) + k) % NUM_CORES);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        next_core_d = next_core_q;
        last_d      = last_q;
        case (state_q)
            IDLE:    if (anyReq) state_d = ADDR;
            ADDR:    if (dmem_hready) state_d = DATA;
            DATA:    if (dmem_hready) state_d = anyReq ? ADDR : IDLE;
            default: state_d = IDLE;
        endcase
        if (arbitrate) begin
            next_core_d = winner;
            last_d      = winner;
        end
    end

    // The owner of an active transfer does not accumulate wait; a fresh winner is cleared.
    always_comb begin
        cnt_d    = cnt_q;
        starve_d = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            starve_d[i] = (cnt_q[i] >= MaxWaitC);
            if (!req[i] || (arbitrate && (winner == CORE_IDX_WIDTH'(i)))) begin
                cnt_d[i] = '0;
            end else if (((state_q == IDLE) || !grant[i]) && (cnt_q[i] != '1)) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            next_core_q <= '0;
            last_q      <= LastIdxC;
            starve_q    <= '0;
            for (int i = 0; i < NUM_CORES; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            next_core_q <= next_core_d;
            last_q      <= last_d;
            starve_q    <= starve_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        grant = '0;
        if (state_q != IDLE) grant[next_core_q] = 1'b1;
    end

    assign next_core   = next_core_q;
    assign busy        = (state_q != IDLE);
    assign starve_flag = starve_q;

endmodule

// File: tb/tb_vscale_dmem_rr_scheduler.sv
// Scoreboard bench for vscale_dmem_rr_scheduler: directed scenarios followed by random traffic,
// expected outputs computed by a phase-level reference model.
module tb_vscale_dmem_rr_scheduler;

    localparam int N       = 4;
    localparam int MAXWAIT = 4;
    localparam int CNTMAX  = 255;

    typedef struct {
        logic [1:0] nc;
        logic [3:0] gr;
        logic       bz;
        logic [3:0] sf;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] core_htrans = '0;
    logic [3:0] core_hmastlock = '0;
    logic       dmem_hready = 1'b1;
    logic [1:0] next_core;
    logic [3:0] grant;
    logic       busy;
    logic [3:0] starve_flag;

    exp_t sb[$];
    bit   armed = 1'b0;
    int   checks = 0;
    int   errors = 0;

    // Reference model: phase 0 = no transfer, 1 = address phase, 2 = data phase.
    int phase = 0;
    int owner = 0;
    int last  = N - 1;
    int waitCnt [N];
    bit starved [N];

    vscale_dmem_rr_scheduler #(
        .NUM_CORES(N), .CORE_IDX_WIDTH(2), .HASTI_TRANS_WIDTH(2),
        .WAIT_CNT_WIDTH(8), .MAX_WAIT(MAXWAIT)
    ) dut (
        .clk(clk), .reset(reset), .core_htrans(core_htrans),
        .core_hmastlock(core_hmastlock), .dmem_hready(dmem_hready),
        .next_core(next_core), .grant(grant), .busy(busy), .starve_flag(starve_flag)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] htFromMask(input logic [3:0] m);
        logic [7:0] h;
        h = '0;
        for (int i = 0; i < N; i++) if (m[i]) h[2*i +: 2] = 2'b10;
        return h;
    endfunction

    task automatic modelStep(input logic [7:0] ht, input logic [3:0] lk, input logic rdy, input logic rst);
        bit req [N];
        bit any;
        bit arb;
        int w;
        int c;
        if (rst) begin
            phase = 0; owner = 0; last = N - 1;
            for (int i = 0; i < N; i++) begin waitCnt[i] = 0; starved[i] = 0; end
            return;
        end
        any = 0;
        for (int i = 0; i < N; i++) begin
            req[i] = (ht[2*i +: 2] == 2'b10) || (ht[2*i +: 2] == 2'b11);
            any |= req[i];
        end
        arb = any && (phase == 0 || (phase == 2 && rdy));
        w = -1;
        for (int i = 0; i < N; i++) if (w < 0 && starved[i] && req[i]) w = i;
        if (w < 0 && phase == 2 && lk[owner] && req[owner]) w = owner;
        for (int k = 1; k <= N; k++) begin
            c = (last + k) % N;
            if (w < 0 && req[c]) w = c;
        end
        for (int i = 0; i < N; i++) begin
            starved[i] = (waitCnt[i] >= MAXWAIT);
            if (!req[i] || (arb && w == i)) waitCnt[i] = 0;
            else if (phase == 0 || owner != i) waitCnt[i] = (waitCnt[i] < CNTMAX) ? waitCnt[i] + 1 : CNTMAX;
        end
        if (arb) begin
            owner = w; last = w; phase = 1;
        end else if (phase == 1 && rdy) phase = 2;
        else if (phase == 2 && rdy) phase = 0;
    endtask

    // Drives one cycle of inputs on the falling edge and queues what the next rising edge must show.
    task automatic applyStimulus(input logic [7:0] ht, input logic [3:0] lk, input logic rdy, input logic rst);
        exp_t e;
        @(negedge clk);
        core_htrans = ht; core_hmastlock = lk; dmem_hready = rdy; reset = rst;
        modelStep(ht, lk, rdy, rst);
        e.nc = 2'(owner);
        e.gr = (phase != 0) ? 4'(1 << owner) : 4'b0000;
        e.bz = (phase != 0);
        for (int i = 0; i < N; i++) e.sf[i] = starved[i];
        sb.push_back(e);
        armed = 1'b1;
    endtask

    task automatic checkOutput(input exp_t e);
        checks++;
        if (next_core !== e.nc) begin errors++; $display("[TB] FAIL next_core @%0t: got %0d, expected %0d", $time, next_core, e.nc); end
        checks++;
        if (grant !== e.gr) begin errors++; $display("[TB] FAIL grant @%0t: got %b, expected %b", $time, grant, e.gr); end
        checks++;
        if (busy !== e.bz) begin errors++; $display("[TB] FAIL busy @%0t: got %b, expected %b", $time, busy, e.bz); end
        checks++;
        if (starve_flag !== e.sf) begin errors++; $display("[TB] FAIL starve_flag @%0t: got %b, expected %b", $time, starve_flag, e.sf); end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (armed) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL scoreboard @%0t: got no expectation, expected one per edge", $time);
                end else begin
                    e = sb.pop_front();
                    checkOutput(e);
                end
            end
        end
    end

    initial begin
        logic [3:0] mask;
        logic [7:0] ht;
        logic [3:0] lk;
        $display("[TB] start");
        repeat (2) applyStimulus(8'h00, 4'h0, 1'b1, 1'b1);
        repeat (10) applyStimulus(8'h00, 4'h0, 1'b1, 1'b0);
        // Single request from core 2, dropped after the grant.
        applyStimulus(htFromMask(4'b0100), 4'h0, 1'b1, 1'b0);
        repeat (3) applyStimulus(8'h00, 4'h0, 1'b1, 1'b0);
        // All cores requesting continuously.
        repeat (12) applyStimulus(8'hFF, 4'h0, 1'b1, 1'b0);
        repeat (2) applyStimulus(8'h00, 4'h0, 1'b1, 1'b0);
        // Core 1 locked with cores 0 and 1 requesting, then lock dropped with core 2 joining.
        repeat (8) applyStimulus(htFromMask(4'b0011), 4'b0010, 1'b1, 1'b0);
        repeat (4) applyStimulus(htFromMask(4'b0111), 4'b0000, 1'b1, 1'b0);
        repeat (2) applyStimulus(8'h00, 4'h0, 1'b1, 1'b0);
        // Core 0 holds a lock while core 3 starves.
        repeat (16) applyStimulus(htFromMask(4'b1001), 4'b0001, 1'b1, 1'b0);
        // Stall in the data phase, then reset during the stall.
        applyStimulus(htFromMask(4'b0001), 4'h0, 1'b1, 1'b0);
        applyStimulus(htFromMask(4'b0001), 4'h0, 1'b1, 1'b0);
        repeat (5) applyStimulus(htFromMask(4'b0001), 4'h0, 1'b0, 1'b0);
        applyStimulus(htFromMask(4'b0001), 4'h0, 1'b0, 1'b1);
        applyStimulus(8'h00, 4'h0, 1'b1, 1'b0);
        // Random traffic with sticky per-core requests so waits build up.
        mask = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < N; i++) if ($urandom_range(7) == 0) mask[i] = ~mask[i];
            ht = '0;
            for (int i = 0; i < N; i++) ht[2*i +: 2] = mask[i] ? 2'($urandom_range(3, 2)) : 2'($urandom_range(1, 0));
            lk = 4'($urandom) & 4'($urandom);
            applyStimulus(ht, lk, ($urandom_range(3) != 0), ($urandom_range(199) == 0));
        end
        @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending expectations, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
